// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master single-port RAM arbiter, IDLE/ACCESS/RESP per access
// RAM_ARB_RR_EN selects round-robin arbitration; otherwise m0 has fixed priority.
module ram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_sel_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    sel_q, sel_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          win;

`ifdef RAM_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        if (m0_req_i && m1_req_i) begin
            win = ptr_q;
        end else begin
            win = m1_req_i;
        end
    end
`else
    // m1 only wins when m0 is silent
    always_comb begin
        win = !m0_req_i;
    end
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef RAM_ARB_RR_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_d = ACCESS;
                    owner_d = win;
                    we_d    = win ? m1_we_i    : m0_we_i;
                    addr_d  = win ? m1_addr_i  : m0_addr_i;
                    sel_d   = win ? m1_sel_i   : m0_sel_i;
                    wdata_d = win ? m1_wdata_i : m0_wdata_i;
`ifdef RAM_ARB_RR_EN
                    ptr_d   = !win;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                // writes report zero read data to the owner
                if (owner_q) begin
                    rdata1_d = we_q ? '0 : ram_data_i;
                end else begin
                    rdata0_d = we_q ? '0 : ram_data_i;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef RAM_ARB_RR_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef RAM_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    logic in_access;
    logic in_resp;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign m0_gnt_o   = in_access && !owner_q;
    assign m1_gnt_o   = in_access &&  owner_q;
    assign m0_ack_o   = in_resp   && !owner_q;
    assign m1_ack_o   = in_resp   &&  owner_q;
    assign m0_rdata_o = rdata0_q;
    assign m1_rdata_o = rdata1_q;

    assign ram_ce_o   = in_access;
    assign ram_we_o   = in_access && we_q;
    assign ram_addr_o = in_access ? addr_q  : '0;
    assign ram_sel_o  = in_access ? sel_q   : '0;
    assign ram_data_o = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against a transaction model
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_sel_i(m0_sel_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_sel_i(m1_sel_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    // RAM device driven by the DUT's RAM port
    logic [31:0] ram_mem [0:255];
    assign ram_data_i = ram_mem[ram_addr_o[9:2]];

    always @(posedge clk) begin
        if (ram_ce_o && ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel_o[b]) ram_mem[ram_addr_o[9:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
            end
        end
    end

    // transaction-level reference
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rdata [2];
    int          n_vec = 0;
    int          n_fail = 0;
    int          e;
    int          acc_t;
    int          idle_at;
    int          acc_w;
    logic        acc_we;
    logic [31:0] acc_addr, acc_wd, acc_rd;
    logic [3:0]  acc_sel;
    logic        ptr;
    logic        pend [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd);
        if (m == 0) begin
            m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_sel_i = sel; m0_wdata_i = wd;
        end else begin
            m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_sel_i = sel; m1_wdata_i = wd;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt0"}, m0_gnt_o, 0);
        chk({tag, "_gnt1"}, m1_gnt_o, 0);
        chk({tag, "_ack0"}, m0_ack_o, 0);
        chk({tag, "_ack1"}, m1_ack_o, 0);
        chk({tag, "_ce"}, ram_ce_o, 0);
        chk({tag, "_we"}, ram_we_o, 0);
        chk({tag, "_addr"}, ram_addr_o, 0);
        chk({tag, "_sel"}, ram_sel_o, 0);
        chk({tag, "_wdat"}, ram_data_o, 0);
        chk({tag, "_rd0"}, m0_rdata_o, 0);
        chk({tag, "_rd1"}, m1_rdata_o, 0);
    endtask

    // one clock: predict what the coming edge does, then check the cycle after it
    task automatic step();
        int   w;
        logic ia, ir;
        e++;
        if (e >= idle_at && (m0_req_i || m1_req_i)) begin
            if (m0_req_i && m1_req_i) begin
`ifdef RAM_ARB_RR_EN
                w = int'(ptr);
`else
                w = 0;
`endif
            end else begin
                w = m1_req_i ? 1 : 0;
            end
            ptr      = (w == 0);
            acc_t    = e;
            acc_w    = w;
            acc_we   = (w == 0) ? m0_we_i    : m1_we_i;
            acc_addr = (w == 0) ? m0_addr_i  : m1_addr_i;
            acc_sel  = (w == 0) ? m0_sel_i   : m1_sel_i;
            acc_wd   = (w == 0) ? m0_wdata_i : m1_wdata_i;
            if (acc_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (acc_sel[b]) ref_mem[acc_addr[9:2]][b*8 +: 8] = acc_wd[b*8 +: 8];
                end
                acc_rd = 32'h0;
            end else begin
                acc_rd = ref_mem[acc_addr[9:2]];
            end
            idle_at = e + 3;
            pend[w] = 1'b0;
        end
        if (e == acc_t + 1) exp_rdata[acc_w] = acc_rd;
        @(negedge clk);
        ia = (e == acc_t);
        ir = (e == acc_t + 1);
        chk("gnt0", m0_gnt_o, ia && acc_w == 0);
        chk("gnt1", m1_gnt_o, ia && acc_w == 1);
        chk("ack0", m0_ack_o, ir && acc_w == 0);
        chk("ack1", m1_ack_o, ir && acc_w == 1);
        chk("ram_ce", ram_ce_o, ia);
        chk("ram_we", ram_we_o, ia && acc_we);
        chk("ram_addr", ram_addr_o, ia ? acc_addr : 32'h0);
        chk("ram_sel", ram_sel_o, ia ? acc_sel : 4'h0);
        chk("ram_data", ram_data_o, ia ? acc_wd : 32'h0);
        chk("rdata0", m0_rdata_o, exp_rdata[0]);
        chk("rdata1", m1_rdata_o, exp_rdata[1]);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        check_zero("rst_in");
        repeat (n) begin
            @(negedge clk);
            e++;
        end
        check_zero("rst_hold");
        rst_n = 1'b1;
        acc_t = -100;
        idle_at = e + 1;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        ptr = 1'b0;
    endtask

    task automatic xact(input int m, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
        drive(m, 1'b1, we, addr, sel, wd);
        step();
        drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
        ram_mem[8] = 32'h55667788; ref_mem[8] = 32'h55667788;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        e = 0;
        @(negedge clk);
        do_reset(2);

        // single read by m0
        xact(0, 1'b0, 32'h10, 4'hF, 32'h0);
        chk("single_read_word", m0_rdata_o, 32'h11223344);

        // byte-lane write by m1, then read back
        xact(1, 1'b1, 32'h20, 4'h2, 32'hAABBCCDD);
        chk("byte_write_rd1", m1_rdata_o, 32'h0);
        xact(1, 1'b0, 32'h20, 4'hF, 32'h0);
        chk("byte_write_word", m1_rdata_o, 32'h5566CC88);

        // continuous contention from reset
        do_reset(1);
        drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        repeat (12) step();
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) step();

        // reset pulse during m0's read ACCESS, request still held
        drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        step();
        chk("rst_mid_gnt", m0_gnt_o, 1'b1);
        do_reset(1);
        step();
        chk("rst_regrant", m0_gnt_o, 1'b1);
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) step();

        // m1 drops req right after gnt
        drive(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("early_drop_ack", m1_ack_o, 1'b1);
        repeat (3) step();

        // randomized traffic; a pending request is held until granted
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    pend[m] = 1'($urandom_range(0, 1));
                    drive(m, pend[m], 1'($urandom), $urandom, 4'($urandom), $urandom);
                end
            end
            step();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the width of the master and RAM address buses.
REQ-002 SHALL have parameter DW, default 32, meaning the width of the write and read data buses; the RAM port has 4 byte lanes.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mN_req_i  input  1  access request from master N (N = 0, 1); m0 is the CPU MEM stage, m1 is the DMA/loader.
REQ-006 mN_we_i  input  1  write request (1) or read request (0).
REQ-007 mN_addr_i  input  AW  byte address.
REQ-008 mN_sel_i  input  4  byte-lane select.
REQ-009 mN_wdata_i  input  DW  write data.
REQ-010 mN_gnt_o  output  1  one-cycle pulse; request captured.
REQ-011 mN_ack_o  output  1  one-cycle pulse; access complete.
REQ-012 mN_rdata_o  output  DW  read data, valid while mN_ack_o is high.
REQ-013 ram_ce_o, ram_we_o  output  1 each  RAM chip enable and write enable.
REQ-014 ram_addr_o  output  AW  RAM address; ram_sel_o  output  4  RAM byte-lane select; ram_data_o  output  DW  RAM write data.
REQ-015 ram_data_i  input  DW  combinational RAM read data.

Function
REQ-016 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE; every state lasts exactly one cycle except IDLE, which waits for a request.
REQ-017 IDLE, with any request asserted: SHALL select the winner, register its we/addr/sel/wdata and the owner ID, pulse the winner's gnt_o on the same edge, and go to ACCESS.
REQ-018 ACCESS: SHALL drive ram_ce_o=1 and ram_we_o=the registered we, and drive the RAM address, select and data buses from the registers.
REQ-019 In the ACCESS state, on a read the ACCESS-to-RESP edge SHALL capture ram_data_i into the owner's rdata register; on a write the RAM commits at that same edge.
REQ-020 RESP: SHALL drive ram_ce_o=0 and pulse the owner's ack_o; rdata_o holds the captured word; on writes rdata_o is 0.
REQ-021 Outside ACCESS: ram_ce_o=0, ram_we_o=0, and ram_addr_o/ram_sel_o/ram_data_o SHALL be 0.
REQ-022 Latency: req sampled at edge E; gnt at E; RAM access during cycle E..E+1; ack high in cycle E+1..E+2; a back-to-back request is first sampled at E+3.
REQ-023 A master SHALL hold req and its payload until gnt; changes after gnt are ignored, and deasserting req after gnt does not cancel the access (ack still pulses).
REQ-024 At most one gnt_o and at most one ack_o SHALL be high in any cycle, and never for a non-owner.
REQ-025 Simultaneous requests SHALL be resolved by the priority rule in REQ-029/REQ-030.
REQ-026 rdata_o of the non-owner SHALL keep its previous value.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, all gnt/ack/ram_* outputs to 0, both rdata registers to 0, and the round-robin pointer to m0.
REQ-028 Reset asserted mid-ACCESS SHALL abort the access with no ack; the RAM write is not guaranteed; after release, the arbiter re-samples requests in IDLE.

Configuration
REQ-029 With macro RAM_ARB_RR_EN defined: round-robin. The pointer names the preferred master, and after each grant the pointer moves to the other master.
REQ-030 With RAM_ARB_RR_EN undefined: fixed priority with m0 always winning; the pointer logic SHALL NOT be present.

Verification
REQ-031 Single read: preload word 0x11223344 at 0x10; m0 reads 0x10 with sel=0xF -> gnt at E, ack at E+1, m0_rdata_o=0x11223344.
REQ-032 Byte write: m1 writes 0xAABBCCDD to 0x20 with sel=0x2, then m1 reads 0x20 -> only bits 15:8 change to 0xCC.
REQ-033 Contention with RAM_ARB_RR_EN: both masters request continuously from reset -> grant order m0, m1, m0, m1, with grants 3 cycles apart.
REQ-034 Contention without RAM_ARB_RR_EN: both masters request continuously -> m0 is granted every time and m1 is never granted.
REQ-035 Reset in ACCESS: rst_n is pulsed low during m0's read ACCESS -> no ack; all outputs are 0 while reset is low; m0 is re-granted 1 cycle after release with its request still held.
REQ-036 Early drop: m1 deasserts req the cycle after gnt -> m1_ack_o still pulses once, and no second grant occurs.
